// File: rtl/divider_32b_iter.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// Operands enter through a val/rdy handshake. The quotient and remainder
// leave through a second val/rdy handshake. The subtract stage is 33 bits
// wide and is built as an add of the complement. Its carry-out selects
// between restoring the partial remainder and keeping the difference.
module divider_32b_iter #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] remainder
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST_STEP = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_quo;   // dividend shifts out the top, quotient bits shift in at the bottom
  logic [NBITS-1:0] r_rem;   // partial remainder, always below the divisor between steps
  logic [NBITS-1:0] r_div;   // divisor captured at the handshake
  logic [CW-1:0]    r_cnt;

  logic [NBITS:0]   w_shift; // partial remainder with the next dividend bit appended
  logic [NBITS:0]   w_diff;  // w_shift minus divisor, as a two's-complement add
  logic             w_fits;  // divisor fits: no borrow out of the 33-bit subtract

  // Subtract by adding the one's complement plus one. Bit NBITS of the
  // result is the borrow: it is set when the divisor exceeds the shifted
  // remainder.
  function automatic logic [NBITS:0] sub_cmpl(input logic [NBITS:0]   a,
                                              input logic [NBITS-1:0] b);
    logic [NBITS:0] b_inv;
    b_inv    = ~{1'b0, b};
    sub_cmpl = a + b_inv + {{NBITS{1'b0}}, 1'b1};
  endfunction

  // One restoring step computed from the working registers.
  always_comb begin
    w_shift = {r_rem, r_quo[NBITS-1]};
    w_diff  = sub_cmpl(w_shift, r_div);
    w_fits  = ~w_diff[NBITS];
  end

  // Handshake flags come from the state register only. The input is also
  // blocked while reset is held.
  assign istream_rdy = (r_state == IDLE) && !rst;
  assign ostream_val = (r_state == DONE);

  // The working registers drive the result ports directly. They hold
  // intermediate values during CALC and are only meaningful under ostream_val.
  assign quotient  = r_quo;
  assign remainder = r_rem;

  // Control FSM and datapath registers. Reset overrides any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (istream_val) begin
            r_quo   <= dividend;
            r_div   <= divisor;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end

        CALC: begin
          if (w_fits) begin
            r_rem <= w_diff[NBITS-1:0];
            r_quo <= {r_quo[NBITS-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[NBITS-1:0];
            r_quo <= {r_quo[NBITS-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_state <= DONE;
          end
        end

        DONE: begin
          // Results stay frozen until the consumer takes them. No new
          // operands are accepted in the same cycle as the output handshake.
          if (ostream_rdy) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32b_iter.sv
// Testbench for divider_32b_iter: directed corner cases plus randomized
// operands, checked against plain integer division.
module tb_divider_32b_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        istream_val;
  logic        istream_rdy;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total = 0;
  int bad   = 0;

  divider_32b_iter dut (
    .clk         (clk),
    .rst         (rst),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .dividend    (dividend),
    .divisor     (divisor),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned division, with RISC-V DIVU/REMU divide-by-zero results.
  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 32'hFFFF_FFFF;
    return a / b;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return a;
    return a % b;
  endfunction

  // Run one division. bp is the number of stalled cycles after ostream_val
  // rises. If pulse_at > 0, garbage operands are offered at that busy cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int bp, input int pulse_at);
    int n;
    logic [31:0] eq;
    logic [31:0] er;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    ostream_rdy = (bp == 0);
    n = 0;
    while (!istream_rdy && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_rdy_before"}, istream_rdy, 1'b1);
    istream_val = 1'b1;
    dividend    = a;
    divisor     = b;
    tick();  // handshake edge closes cycle T; we are now in T+1
    istream_val = 1'b0;
    dividend    = $urandom;
    divisor     = $urandom;
    n = 1;
    while (!ostream_val && n < 100) begin
      if (istream_rdy) chk({tag, "_rdy_busy"}, istream_rdy, 1'b0);
      if (pulse_at > 0 && n == pulse_at) begin
        istream_val = 1'b1;
        dividend    = 32'd9;
        divisor     = 32'd3;
      end else begin
        istream_val = 1'b0;
      end
      tick();
      n++;
    end
    istream_val = 1'b0;
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_quot"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_rdy_done"}, istream_rdy, 1'b0);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({tag, "_bp_val"}, ostream_val, 1'b1);
      chk({tag, "_bp_rdy"}, istream_rdy, 1'b0);
      chk({tag, "_bp_quot"}, quotient, eq);
      chk({tag, "_bp_rem"}, remainder, er);
    end
    ostream_rdy = 1'b1;
    tick();  // output handshake
    chk({tag, "_val_after"}, ostream_val, 1'b0);
    chk({tag, "_rdy_after"}, istream_rdy, 1'b1);
  endtask

  initial begin
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;
    rst         = 1'b1;
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    dividend    = '0;
    divisor     = '0;
    tick();
    tick();
    chk("reset_irdy", istream_rdy, 1'b0);
    chk("reset_oval", ostream_val, 1'b0);
    chk("reset_quot", quotient, 32'd0);
    chk("reset_rem", remainder, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_irdy_rel", istream_rdy, 1'b1);

    do_op("d100_7", 32'd100, 32'd7, 0, 0);
    chk("d100_7_model", ref_q(32'd100, 32'd7), 32'd14);
    do_op("div0", 32'h1234_5678, 32'd0, 0, 0);
    do_op("max_1", 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op("small", 32'd5, 32'd10, 0, 0);
    do_op("bp", 32'd1000, 32'd33, 5, 0);
    do_op("busy", 32'd50, 32'd5, 0, 4);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ostream_val) seen++;
    end
    chk("busy_no_second", seen, 0);

    // Reset in the middle of a computation.
    istream_val = 1'b1;
    dividend    = 32'd200;
    divisor     = 32'd3;
    tick();  // now in T+1
    istream_val = 1'b0;
    for (int i = 0; i < 9; i++) tick();  // now in T+10
    rst = 1'b1;
    tick();
    chk("mid_rst_irdy", istream_rdy, 1'b0);
    chk("mid_rst_oval", ostream_val, 1'b0);
    chk("mid_rst_quot", quotient, 32'd0);
    chk("mid_rst_rem", remainder, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_irdy_rel", istream_rdy, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ostream_val) seen++;
    end
    chk("mid_rst_no_out", seen, 0);
    do_op("after_rst", 32'd81, 32'd9, 0, 0);

    // Randomized operands, including zero and narrow divisors.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 6 == 0) rb = 32'd0;
      if (i % 5 == 1) ra = ra >> $urandom_range(0, 31);
      do_op("rand", ra, rb, $urandom_range(0, 3), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
